mips_multicycle: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS core.
- One FSM-sequenced datapath shares a single memory port for instruction and data, over a req/ready handshake with arbitrary wait states.
- Adds bne, addi, a halt/trap state on illegal opcode or misaligned access, and a retire strobe for the bench.
- Top-level core; the register file and ALU are internal.

---
 rtl/mips_multicycle.sv | 152 +++++++++++++++
 tb/tb_mips_multicycle.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// mips_multicycle: FSM-sequenced MIPS subset core sharing one req/ready memory port for fetch and data.
module mips_multicycle #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  halted,
  output logic                  retire_valid,
  output logic [31:0]           retire_pc
);
  localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ipc_q, ir_q, a_q, b_q, alu_q, alu_d, mdr_q;
  logic [31:0] rf_q [NUM_REGS];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wb_idx;
  logic [31:0] simm, ea, alu_r;
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, legal, taken;
  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign fn      = ir_q[5:0];
  assign simm    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign is_r    = op == 6'h00;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign is_addi = op == 6'h08;
  assign is_j    = op == 6'h02;
  assign legal   = (is_r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A))
                 || is_lw || is_sw || is_beq || is_bne || is_addi || is_j;
  assign ea      = a_q + simm;
  assign taken   = is_beq ? a_q == b_q : a_q != b_q;
  assign alu_r   = fn == 6'h20 ? a_q + b_q :
                   fn == 6'h22 ? a_q - b_q :
                   fn == 6'h24 ? a_q & b_q :
                   fn == 6'h25 ? a_q | b_q : {31'b0, $signed(a_q) < $signed(b_q)};
  assign wb_idx  = is_r ? rd : rt;
  assign retire_pc = ipc_q;
  // Register 0 and indices beyond NUM_REGS are hardwired to zero.
  function automatic logic [31:0] rreg(input logic [4:0] i);
    return (i != 5'd0 && 32'(i) < NUM_REGS) ? rf_q[i[RW-1:0]] : 32'h0;
  endfunction
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    alu_d = alu_q;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    halted = 1'b0;
    retire_valid = 1'b0;
    case (state_q)
      FETCH: begin
        if (pc_q[1:0] != 2'b00) state_d = HALT;
        else begin
          mem_req = 1'b1;
          mem_addr = pc_q[ADDR_WIDTH-1:0];
          if (mem_ready) begin
            pc_d = pc_q + 32'd4;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        alu_d = pc_q + (simm << 2);
        if (!legal) state_d = HALT;
        else if (is_j) begin
          pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire_valid = 1'b1;
          state_d = FETCH;
        end else state_d = EXEC;
      end
      EXEC: begin
        if (is_r || is_addi) begin
          alu_d = is_r ? alu_r : ea;
          state_d = WB;
        end else if (is_lw || is_sw) begin
          alu_d = ea;
          state_d = ea[1:0] != 2'b00 ? HALT : MEM;
        end else begin
          pc_d = taken ? alu_q : pc_q;
          retire_valid = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we = is_sw;
        mem_addr = alu_q[ADDR_WIDTH-1:0];
        mem_wdata = b_q;
        if (mem_ready) begin
          retire_valid = is_sw;
          state_d = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        retire_valid = 1'b1;
        state_d = FETCH;
      end
      default: halted = 1'b1;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we = 1'b0;
      mem_addr = '0;
      mem_wdata = '0;
      halted = 1'b0;
      retire_valid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ipc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      alu_q <= alu_d;
      if (state_q == FETCH && state_d == DECODE) begin
        ir_q <= mem_rdata;
        ipc_q <= pc_q;
      end
      if (state_q == DECODE) begin
        a_q <= rreg(rs);
        b_q <= rreg(rt);
      end
      if (state_q == MEM && state_d == WB) mdr_q <= mem_rdata;
      if (state_q == WB && wb_idx != 5'd0 && 32'(wb_idx) < NUM_REGS)
        rf_q[wb_idx[RW-1:0]] <= is_lw ? mdr_q : alu_q;
    end
  end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed programs with a wait-state memory model and a queue-based retire/store scoreboard.
module tb_mips_multicycle;
  logic clk, reset, mem_req, mem_we, mem_ready, halted, retire_valid;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, retire_pc;
  mips_multicycle dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
    .retire_valid(retire_valid), .retire_pc(retire_pc)
  );
  logic [31:0] mem [1024];
  logic [31:0] rq[$];
  logic [63:0] wq[$];
  int rlog[$];
  int total = 0, bad = 0, cyc = 0, waits = 0, wcnt = 0, pcnt = 0, nreq = 0, nhs = 0, hcyc = -1, fst = -1;
  logic force_rdy = 1'b0, patch_en = 1'b0, pend = 1'b0, p_we = 1'b0;
  logic [11:0] p_addr = '0;
  logic [31:0] p_wdata = '0, patch_w = '0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 1 : cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction
  // Memory: ready after `waits` stalled cycles; optionally rewrites the word at 0x10 after its third fetch.
  always @(negedge clk) begin
    if (force_rdy) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hFC00_0000;
      wcnt = 0;
    end else if (reset || !mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (wcnt >= waits) begin
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr[11:2]];
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      else if (patch_en && mem_addr == 12'h010) begin
        pcnt++;
        if (pcnt == 3) mem[4] = patch_w;
      end
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      wcnt++;
    end
  end
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (!reset) begin
      if (pend) begin
        chk("hold_ctl", {mem_req, mem_we, 18'b0, mem_addr}, {1'b1, p_we, 18'b0, p_addr});
        chk("hold_wdata", mem_wdata, p_wdata);
      end
      if (mem_req && !pend && !mem_we && mem_addr == 12'h108) fst = cyc;
      if (mem_req) nreq++;
      if (mem_req && mem_ready) nhs++;
      if (retire_valid) begin
        rlog.push_back(cyc);
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL retire_unexp: got pc %h want none", retire_pc);
        end else chk("retire_pc", retire_pc, rq.pop_front());
      end
      if (mem_req && mem_we && mem_ready) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL write_unexp: got %h@%h want none", mem_wdata, mem_addr);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", {20'b0, mem_addr}, e[63:32]);
          chk("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (halted && hcyc < 0) hcyc = cyc;
    end
    pend = !reset && mem_req && !mem_ready;
    p_we = mem_we;
    p_addr = mem_addr;
    p_wdata = mem_wdata;
  end
  task automatic init(input int w);
    reset = 1'b1;
    force_rdy = 1'b0;
    patch_en = 1'b0;
    waits = w;
    pcnt = 0;
    nreq = 0;
    nhs = 0;
    hcyc = -1;
    fst = -1;
    rq.delete();
    wq.delete();
    rlog.delete();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask
  task automatic release_rst(input int n);
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic run_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("halt_reached", {31'b0, halted}, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    chk("retire_left", 32'(rq.size()), 32'd0);
    chk("write_left", 32'(wq.size()), 32'd0);
  endtask
  initial begin
    int n0;
    reset = 1'b1;
    // addi chain, stores, illegal opcode; zero wait states
    init(0);
    mem[0] = enc_i(6'h08, 0, 1, 16'h0005);
    mem[1] = enc_i(6'h08, 1, 2, 16'hFFF9);
    mem[2] = enc_i(6'h2B, 0, 1, 16'h0080);
    mem[3] = enc_i(6'h2B, 0, 2, 16'h0084);
    mem[4] = 32'hFC00_0000;
    for (int i = 0; i < 4; i++) rq.push_back(32'(i * 4));
    wq.push_back({32'h80, 32'h5});
    wq.push_back({32'h84, 32'hFFFF_FFFE});
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", {26'b0, mem_req, mem_we, halted, retire_valid, |mem_addr, |mem_wdata}, 32'd0);
    release_rst(1);
    #1 chk("first_fetch", {19'b0, mem_req, mem_addr}, {19'b0, 1'b1, 12'h000});
    run_halt(200);
    if (rlog.size() >= 2) begin
      chk("retire_cyc0", 32'(rlog[0]), 32'd4);
      chk("retire_cyc1", 32'(rlog[1]), 32'd8);
    end
    chk("halt_cyc_op3f", 32'(hcyc), 32'd19);
    // R-type ALU, signed slt, write to $0, illegal funct; one wait state
    init(1);
    mem[0]  = enc_i(6'h23, 0, 1, 16'h0200);
    mem[1]  = enc_i(6'h08, 0, 2, 16'h0001);
    mem[2]  = enc_r(1, 2, 3, 6'h20);
    mem[3]  = enc_r(1, 2, 4, 6'h22);
    mem[4]  = enc_r(1, 2, 5, 6'h24);
    mem[5]  = enc_r(1, 2, 6, 6'h25);
    mem[6]  = enc_r(1, 2, 7, 6'h2A);
    for (int i = 0; i < 5; i++) mem[7 + i] = enc_i(6'h2B, 0, 5'(3 + i), 16'(16'h0300 + 4 * i));
    mem[12] = enc_i(6'h08, 0, 1, 16'hFFFF);
    mem[13] = enc_r(2, 1, 8, 6'h2A);
    mem[14] = enc_r(1, 2, 9, 6'h2A);
    mem[15] = enc_i(6'h08, 0, 0, 16'h0009);
    mem[16] = enc_i(6'h2B, 0, 8, 16'h0314);
    mem[17] = enc_i(6'h2B, 0, 9, 16'h0318);
    mem[18] = enc_i(6'h2B, 0, 0, 16'h031C);
    mem[128] = 32'h7FFF_FFFF;
    for (int i = 0; i < 19; i++) rq.push_back(32'(i * 4));
    wq.push_back({32'h300, 32'h8000_0000});
    wq.push_back({32'h304, 32'h7FFF_FFFE});
    wq.push_back({32'h308, 32'h0000_0001});
    wq.push_back({32'h30C, 32'h7FFF_FFFF});
    wq.push_back({32'h310, 32'h0000_0000});
    wq.push_back({32'h314, 32'h0000_0000});
    wq.push_back({32'h318, 32'h0000_0001});
    wq.push_back({32'h31C, 32'h0000_0000});
    release_rst(3);
    run_halt(600);
    // store/load round trip with three wait states per request
    init(3);
    mem[0]    = enc_j(26'h40);
    mem[8'h40] = enc_i(6'h08, 0, 1, 16'h1234);
    mem[8'h41] = enc_i(6'h2B, 0, 1, 16'h0008);
    mem[8'h42] = enc_i(6'h23, 0, 4, 16'h0008);
    mem[8'h43] = enc_i(6'h2B, 0, 4, 16'h000C);
    mem[8'h44] = 32'hFC00_0000;
    rq.push_back(32'h0);
    rq.push_back(32'h100);
    rq.push_back(32'h104);
    rq.push_back(32'h108);
    rq.push_back(32'h10C);
    wq.push_back({32'h8, 32'h1234});
    wq.push_back({32'hC, 32'h1234});
    release_rst(3);
    run_halt(600);
    if (rlog.size() >= 4) chk("lw_latency", 32'(rlog[3] - fst), 32'd10);
    // beq to self (new instruction each fetch), bne not taken, j
    init(0);
    mem[0] = enc_j(26'h4);
    mem[4] = enc_i(6'h04, 0, 0, 16'hFFFF);
    mem[5] = enc_j(26'h40);
    mem[8'h40] = enc_i(6'h08, 0, 3, 16'h0055);
    mem[8'h41] = enc_i(6'h2B, 0, 3, 16'h0200);
    mem[8'h42] = 32'hFC00_0000;
    patch_w = enc_i(6'h05, 0, 0, 16'hFFFF);
    patch_en = 1'b1;
    rq.push_back(32'h0);
    for (int i = 0; i < 4; i++) rq.push_back(32'h10);
    rq.push_back(32'h14);
    rq.push_back(32'h100);
    rq.push_back(32'h104);
    wq.push_back({32'h200, 32'h55});
    release_rst(3);
    run_halt(300);
    if (rlog.size() >= 3) begin
      chk("j_latency", 32'(rlog[0]), 32'd2);
      chk("beq_latency", 32'(rlog[2] - rlog[1]), 32'd3);
    end
    // illegal opcode: halted after DECODE, then silent
    init(0);
    mem[0] = enc_i(6'h08, 0, 1, 16'h0001);
    mem[1] = 32'hFC00_0000;
    rq.push_back(32'h0);
    release_rst(3);
    run_halt(100);
    chk("halt_cyc_ill", 32'(hcyc), 32'd7);
    n0 = nreq;
    repeat (20) @(negedge clk);
    #2;
    chk("halt_no_req", 32'(nreq - n0), 32'd0);
    chk("halt_sticky", {31'b0, halted}, 32'd1);
    // misaligned lw traps from EXEC without a data request
    init(2);
    mem[0] = enc_i(6'h23, 0, 1, 16'h0006);
    release_rst(3);
    run_halt(100);
    chk("misalign_hs", 32'(nhs), 32'd1);
    chk("halt_cyc_mis", 32'(hcyc), 32'd6);
    // reset during a stalled fetch; ready during reset must be ignored
    init(20);
    mem[0] = enc_i(6'h08, 0, 5, 16'h0007);
    mem[1] = enc_i(6'h2B, 0, 5, 16'h0040);
    mem[2] = 32'hFC00_0000;
    rq.push_back(32'h0);
    rq.push_back(32'h4);
    wq.push_back({32'h40, 32'h7});
    release_rst(3);
    repeat (5) @(negedge clk);
    #2 chk("stall_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    force_rdy = 1'b1;
    #1 chk("rst_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    force_rdy = 1'b0;
    waits = 0;
    #1 chk("restart_fetch", {19'b0, mem_req, mem_addr}, {19'b0, 1'b1, 12'h000});
    run_halt(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
